// File: rtl/reg_file_sb_if.sv
// rtl/reg_file_sb_if.sv - pipeline-side bus of the scoreboarded register file
interface reg_file_sb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              ready;
  logic [ADDR_W-1:0] sr1;
  logic [ADDR_W-1:0] sr2;
  logic [DATA_W-1:0] sr1_out;
  logic [DATA_W-1:0] sr2_out;
  logic              sr1_busy;
  logic              sr2_busy;
  logic              we;
  logic [ADDR_W-1:0] dr;
  logic [DATA_W-1:0] data_in;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_dr;
  logic              flush;

  modport master (
    input  ready, sr1_out, sr2_out, sr1_busy, sr2_busy,
    output sr1, sr2, we, dr, data_in, rsv_en, rsv_dr, flush
  );

  modport slave (
    output ready, sr1_out, sr2_out, sr1_busy, sr2_busy,
    input  sr1, sr2, we, dr, data_in, rsv_en, rsv_dr, flush
  );
endinterface

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with busy scoreboard, write bypass and init sequencer
module reg_file_sb #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 3,
  parameter int INIT_BASE = 1,
  parameter int BYPASS    = 1
) (
  input logic          clk,
  input logic          reset,
  reg_file_sb_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic              run;
  logic              hit1, hit2;

  assign run  = (state_q == RUN);
  assign hit1 = (BYPASS != 0) && bus.we && (bus.dr == bus.sr1);
  assign hit2 = (BYPASS != 0) && bus.we && (bus.dr == bus.sr2);

  // Next-state: init sweep fills storage; in RUN apply write, then flush, then reservation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    mem_d   = mem_q;
    if (state_q == INIT) begin
      mem_d[cnt_q] = DATA_W'(INIT_BASE) + DATA_W'(cnt_q);
      cnt_d        = cnt_q + 1'b1;
      if (cnt_q == ADDR_W'(DEPTH - 1)) begin
        state_d = RUN;
      end
    end else begin
      if (bus.we) begin
        mem_d[bus.dr]  = bus.data_in;
        busy_d[bus.dr] = 1'b0;
      end
      if (bus.flush) begin
        busy_d = '0;
      end
      if (bus.rsv_en) begin
        busy_d[bus.rsv_dr] = 1'b1;
      end
    end
    ready_d = (state_d == RUN);
  end

  // Control state and scoreboard; reset restarts the init sweep
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
      busy_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  // Storage keeps its contents through reset; the init sweep rewrites it afterwards
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q <= mem_d;
    end
  end

  // Asynchronous reads with optional forwarding of the write in flight
  always_comb begin
    bus.sr1_out  = '0;
    bus.sr2_out  = '0;
    bus.sr1_busy = 1'b0;
    bus.sr2_busy = 1'b0;
    if (run) begin
      bus.sr1_out  = hit1 ? bus.data_in : mem_q[bus.sr1];
      bus.sr2_out  = hit2 ? bus.data_in : mem_q[bus.sr2];
      bus.sr1_busy = hit1 ? 1'b0 : busy_q[bus.sr1];
      bus.sr2_busy = hit2 ? 1'b0 : busy_q[bus.sr2];
    end
  end

  assign bus.ready = ready_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - randomized model-checked bench for reg_file_sb, bypass and no-bypass builds
module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  sr1, sr2, dr, rsv_dr;
  logic [15:0] data_in;
  logic        we, rsv_en, flush;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_sb_if #(.DATA_W(16), .ADDR_W(3)) if_a ();
  reg_file_sb_if #(.DATA_W(16), .ADDR_W(3)) if_b ();

  assign if_a.sr1 = sr1;      assign if_b.sr1 = sr1;
  assign if_a.sr2 = sr2;      assign if_b.sr2 = sr2;
  assign if_a.we = we;        assign if_b.we = we;
  assign if_a.dr = dr;        assign if_b.dr = dr;
  assign if_a.data_in = data_in; assign if_b.data_in = data_in;
  assign if_a.rsv_en = rsv_en; assign if_b.rsv_en = rsv_en;
  assign if_a.rsv_dr = rsv_dr; assign if_b.rsv_dr = rsv_dr;
  assign if_a.flush = flush;  assign if_b.flush = flush;

  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .INIT_BASE(1), .BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .bus(if_a.slave));
  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .INIT_BASE(1), .BYPASS(0)) u_nob (
    .clk(clk), .reset(reset), .bus(if_b.slave));

  // index 0 = bypass build, index 1 = no-bypass build
  logic [15:0] o1 [2];
  logic [15:0] o2 [2];
  logic        b1 [2];
  logic        b2 [2];
  logic        rdy [2];
  assign o1[0] = if_a.sr1_out;  assign o1[1] = if_b.sr1_out;
  assign o2[0] = if_a.sr2_out;  assign o2[1] = if_b.sr2_out;
  assign b1[0] = if_a.sr1_busy; assign b1[1] = if_b.sr1_busy;
  assign b2[0] = if_a.sr2_busy; assign b2[1] = if_b.sr2_busy;
  assign rdy[0] = if_a.ready;   assign rdy[1] = if_b.ready;

  // Reference model: register contents, busy set, and progress of the init sweep
  logic [15:0] m_mem [8];
  logic [7:0]  m_busy = '0;
  bit          m_run = 1'b0;
  int          m_pos = 0;

  task automatic model_edge();
    if (reset) begin
      m_run = 1'b0; m_pos = 0; m_busy = '0;
    end else if (!m_run) begin
      m_mem[m_pos] = 16'(1 + m_pos);
      m_pos++;
      if (m_pos == 8) begin m_run = 1'b1; m_pos = 0; end
    end else begin
      if (we) begin m_mem[dr] = data_in; m_busy[dr] = 1'b0; end
      if (flush) m_busy = '0;
      if (rsv_en) m_busy[rsv_dr] = 1'b1;
    end
  endtask

  function automatic logic [15:0] exp_out(input int k, input logic [2:0] a);
    if (!m_run) return 16'h0;
    if (k == 0 && we && dr == a) return data_in;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input int k, input logic [2:0] a);
    if (!m_run) return 1'b0;
    if (k == 0 && we && dr == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    we = 0; rsv_en = 0; flush = 0; dr = 0; rsv_dr = 0; data_in = 0;
  endtask

  task automatic test_reset();
    int cnt [2];
    idle(); sr1 = 0; sr2 = 0; reset = 1;
    tick(); tick();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rdy[k] !== 1'b0 || o1[k] !== 16'h0 || b1[k] !== 1'b0 || o2[k] !== 16'h0 || b2[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state dut%0d got rdy=%b o1=%h b1=%b o2=%h b2=%b exp all 0", k, rdy[k], o1[k], b1[k], o2[k], b2[k]);
      end
    end
    reset = 0;
    cnt[0] = 0; cnt[1] = 0;
    for (int i = 0; i < 20; i++) begin
      if (rdy[0] === 1'b1 && rdy[1] === 1'b1) break;
      for (int k = 0; k < 2; k++) if (rdy[k] !== 1'b1) cnt[k]++;
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (cnt[k] != 8) begin
        errors++;
        $display("FAIL init_cycles dut%0d got %0d exp 8", k, cnt[k]);
      end
    end
  endtask

  task automatic test_init_values();
    for (int i = 0; i < 8; i++) begin
      sr1 = 3'(i); sr2 = 3'(7 - i);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o1[k] !== 16'(i + 1) || o2[k] !== 16'(8 - i) || b1[k] !== 1'b0 || b2[k] !== 1'b0) begin
          errors++;
          $display("FAIL init_value dut%0d r%0d got %h/%h busy %b/%b exp %h/%h busy 0/0",
                   k, i, o1[k], o2[k], b1[k], b2[k], 16'(i + 1), 16'(8 - i));
        end
      end
    end
  endtask

  task automatic test_write_bypass();
    idle(); sr1 = 3; we = 1; dr = 3; data_in = 16'hBEEF;
    #1;
    checks++;
    if (o1[0] !== 16'hBEEF) begin errors++; $display("FAIL bypass_same_cycle got %h exp beef", o1[0]); end
    checks++;
    if (o1[1] !== 16'h0004) begin errors++; $display("FAIL nobypass_before_edge got %h exp 0004", o1[1]); end
    tick(); idle(); #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o1[k] !== 16'hBEEF) begin errors++; $display("FAIL write_after_edge dut%0d got %h exp beef", k, o1[k]); end
    end
  endtask

  task automatic test_reserve();
    idle(); sr2 = 5; rsv_en = 1; rsv_dr = 5;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (b2[k] !== 1'b0) begin errors++; $display("FAIL rsv_not_yet dut%0d got %b exp 0", k, b2[k]); end
    end
    tick(); idle(); #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (b2[k] !== 1'b1) begin errors++; $display("FAIL rsv_visible dut%0d got %b exp 1", k, b2[k]); end
    end
    we = 1; dr = 5; data_in = 16'h0007;
    #1;
    checks++;
    if (b2[0] !== 1'b0 || o2[0] !== 16'h0007) begin
      errors++; $display("FAIL wb_bypass_clear got busy %b data %h exp 0 0007", b2[0], o2[0]);
    end
    checks++;
    if (b2[1] !== 1'b1 || o2[1] !== 16'h0006) begin
      errors++; $display("FAIL wb_nobypass got busy %b data %h exp 1 0006", b2[1], o2[1]);
    end
    tick(); idle(); #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (b2[k] !== 1'b0 || o2[k] !== 16'h0007) begin
        errors++; $display("FAIL wb_after_edge dut%0d got busy %b data %h exp 0 0007", k, b2[k], o2[k]);
      end
    end
  endtask

  task automatic test_we_rsv_same();
    idle(); we = 1; dr = 2; data_in = 16'h0009; rsv_en = 1; rsv_dr = 2;
    tick(); idle(); sr1 = 2; #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o1[k] !== 16'h0009 || b1[k] !== 1'b1) begin
        errors++; $display("FAIL we_rsv_same dut%0d got %h busy %b exp 0009 busy 1", k, o1[k], b1[k]);
      end
    end
  endtask

  task automatic test_flush_rsv();
    logic [2:0] regs [3];
    regs[0] = 1; regs[1] = 4; regs[2] = 6;
    for (int i = 0; i < 3; i++) begin
      idle(); rsv_en = 1; rsv_dr = regs[i]; tick();
    end
    idle(); flush = 1; rsv_en = 1; rsv_dr = 4;
    tick(); idle();
    for (int r = 0; r < 8; r++) begin
      sr1 = 3'(r); #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (b1[k] !== (r == 4)) begin
          errors++; $display("FAIL flush_rsv dut%0d r%0d got %b exp %b", k, r, b1[k], (r == 4));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      sr1 = 3'($urandom); sr2 = 3'($urandom); dr = 3'($urandom); rsv_dr = 3'($urandom);
      data_in = 16'($urandom);
      we = 1'($urandom_range(0, 1));
      rsv_en = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 9) == 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o1[k] !== exp_out(k, sr1) || o2[k] !== exp_out(k, sr2) ||
            b1[k] !== exp_busy(k, sr1) || b2[k] !== exp_busy(k, sr2)) begin
          errors++;
          $display("FAIL random dut%0d it%0d got %h/%h busy %b/%b exp %h/%h busy %b/%b", k, n,
                   o1[k], o2[k], b1[k], b2[k], exp_out(k, sr1), exp_out(k, sr2), exp_busy(k, sr1), exp_busy(k, sr2));
        end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid_init();
    int cnt [2];
    idle(); reset = 1; tick();
    reset = 0; tick(); tick(); tick();
    reset = 1; we = 1; dr = 0; data_in = 16'hFFFF;
    tick();
    reset = 0;
    cnt[0] = 0; cnt[1] = 0;
    for (int i = 0; i < 20; i++) begin
      if (rdy[0] === 1'b1 && rdy[1] === 1'b1) break;
      for (int k = 0; k < 2; k++) if (rdy[k] !== 1'b1) cnt[k]++;
      we = 1; dr = 3'($urandom); data_in = 16'hFFFF; rsv_en = 1; rsv_dr = 3'($urandom); flush = 0;
      tick();
    end
    idle();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (cnt[k] != 8) begin errors++; $display("FAIL reinit_cycles dut%0d got %0d exp 8", k, cnt[k]); end
    end
    for (int r = 0; r < 8; r++) begin
      sr1 = 3'(r); sr2 = 3'(r); #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o1[k] !== 16'(r + 1) || b1[k] !== 1'b0 || o2[k] !== exp_out(k, sr2)) begin
          errors++; $display("FAIL reinit_value dut%0d r%0d got %h busy %b exp %h busy 0", k, r, o1[k], b1[k], 16'(r + 1));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_init_values();
    test_write_bypass();
    test_reserve();
    test_we_rsv_same();
    test_flush_rsv();
    test_random();
    test_reset_mid_init();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
